// File: rtl/pipelined_addsub_if.sv
// Handshake bundle for pipelined_addsub: operand beat in, result beat out.
// ADDSUB_OVF_EN adds the out_ovf signal alongside out_sum.
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
`ifdef ADDSUB_OVF_EN
  logic             out_ovf;
`endif

  // Producer/consumer side (testbench or upstream logic)
  modport master (
    output in_valid, in_x, in_y, in_sub, out_ready,
    input  in_ready, out_valid, out_sum
`ifdef ADDSUB_OVF_EN
    , input out_ovf
`endif
  );

  // Adder side
  modport slave (
    input  in_valid, in_x, in_y, in_sub, out_ready,
    output in_ready, out_valid, out_sum
`ifdef ADDSUB_OVF_EN
    , output out_ovf
`endif
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor. The carry chain is cut into STAGES segments of
// SEG bits; each beat carries its remaining operand bits and finished sum bits down the pipe.
// A single global stall enable freezes the whole pipe while the output is held.
// Optional: define ADDSUB_OVF_EN to build the signed-overflow flag out_ovf.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input logic                clk,
  input logic                rst,
  pipelined_addsub_if.slave  bus
);
  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  if ((WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES");
  end

  // Per-stage registers: valid, effective x, y, partial sum, carry into next segment
  logic [STAGES-1:0] r_vld;
  logic [WIDTH-1:0]  r_x [STAGES];
  logic [WIDTH-1:0]  r_y [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic [STAGES-1:0] r_c;

  // Stage inputs (from the port for stage 0, from the previous register otherwise)
  logic [WIDTH-1:0]  w_src_x [STAGES];
  logic [WIDTH-1:0]  w_src_y [STAGES];
  logic [WIDTH-1:0]  w_src_s [STAGES];
  logic [STAGES-1:0] w_src_c;
  logic [STAGES-1:0] w_src_v;
  logic [SEG:0]      w_seg   [STAGES];
  logic [WIDTH-1:0]  w_nxt_s [STAGES];
  logic [STAGES-1:0] w_nxt_c;
  logic              w_adv;

  // Whole pipe moves only when the output slot is empty or being consumed
  assign w_adv = !r_vld[LAST] || bus.out_ready;

  // Segment adders: stage k fills sum bits [k*SEG +: SEG] and produces the next carry
  always_comb begin
    w_src_x[0] = bus.in_x ^ {WIDTH{bus.in_sub}};
    w_src_y[0] = bus.in_y;
    w_src_s[0] = '0;
    w_src_c[0] = bus.in_sub;
    w_src_v[0] = bus.in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      w_src_x[k] = r_x[k-1];
      w_src_y[k] = r_y[k-1];
      w_src_s[k] = r_s[k-1];
      w_src_c[k] = r_c[k-1];
      w_src_v[k] = r_vld[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      w_seg[k]   = {1'b0, w_src_x[k][k*SEG +: SEG]} + {1'b0, w_src_y[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, w_src_c[k]};
      w_nxt_s[k] = w_src_s[k];
      w_nxt_s[k][k*SEG +: SEG] = w_seg[k][SEG-1:0];
      w_nxt_c[k] = w_seg[k][SEG];
    end
  end

  // Pipeline registers: cleared on reset, frozen together during a stall
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_c   <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_x[k] <= '0;
        r_y[k] <= '0;
        r_s[k] <= '0;
      end
    end else if (w_adv) begin
      r_vld <= w_src_v;
      r_c   <= w_nxt_c;
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_x[k] <= w_src_x[k];
        r_y[k] <= w_src_y[k];
        r_s[k] <= w_nxt_s[k];
      end
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_vld[LAST];
  assign bus.out_sum   = {r_c[LAST], r_s[LAST]};

`ifdef ADDSUB_OVF_EN
  logic r_ovf;
  logic w_ovf;

  // Carry into the MSB is recovered as x^y^sum at that bit; XOR with carry out of the MSB
  assign w_ovf = w_src_x[LAST][WIDTH-1] ^ w_src_y[LAST][WIDTH-1]
               ^ w_nxt_s[LAST][WIDTH-1] ^ w_nxt_c[LAST];

  // Overflow flag travels with the final stage register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= w_ovf;
    end
  end

  assign bus.out_ovf = r_ovf;
`endif
endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=8, STAGES=2).
// Directed scenarios plus a randomized stream checked against an arithmetic reference model.
// Build with ADDSUB_OVF_EN defined to also exercise out_ovf.
module tb_pipelined_addsub;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned STAGES = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pipelined_addsub_if #(.WIDTH(WIDTH)) bus ();

  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic; subtract as 2^WIDTH + y - x so bit WIDTH is "no borrow"
  function automatic logic [WIDTH:0] model_sum(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic sub);
    logic [31:0] r;
    if (sub) r = (32'd1 << WIDTH) + 32'(y) - 32'(x);
    else     r = 32'(y) + 32'(x);
    return r[WIDTH:0];
  endfunction

`ifdef ADDSUB_OVF_EN
  function automatic logic model_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic sub);
    int xs, ys, res;
    xs = int'(x);
    ys = int'(y);
    if (xs >= (1 << (WIDTH-1))) xs -= (1 << WIDTH);
    if (ys >= (1 << (WIDTH-1))) ys -= (1 << WIDTH);
    res = sub ? ys - xs : ys + xs;
    return (res > (1 << (WIDTH-1)) - 1) || (res < -(1 << (WIDTH-1)));
  endfunction
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic sub);
    bus.in_valid = v;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_sub   = sub;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_sum !== '0 || bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_state: out_valid=%b out_sum=%h in_ready=%b, required 0 000 1",
               bus.out_valid, bus.out_sum, bus.in_ready);
    end
  endtask

  task automatic test_carry_chain;
    bus.out_ready = 1'b1;
    drive(1'b1, 8'h01, 8'hFF, 1'b0);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL carry_accept: in_ready=%b, required 1", bus.in_ready);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL carry_early: out_valid=%b one cycle after accept, required 0", bus.out_valid);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 9'h100) begin
      n_errors++;
      $display("FAIL carry_chain: out_valid=%b out_sum=%h, required 1 100",
               bus.out_valid, bus.out_sum);
    end
    tick();
  endtask

  task automatic test_subtract;
    bus.out_ready = 1'b1;
    drive(1'b1, 8'h03, 8'h05, 1'b1);
    tick();
    drive(1'b1, 8'h05, 8'h03, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 9'h102) begin
      n_errors++;
      $display("FAIL sub_no_borrow: out_valid=%b out_sum=%h, required 1 102",
               bus.out_valid, bus.out_sum);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 9'h0FE) begin
      n_errors++;
      $display("FAIL sub_borrow: out_valid=%b out_sum=%h, required 1 0fe",
               bus.out_valid, bus.out_sum);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [WIDTH:0] exp_v [4];
    logic [WIDTH-1:0] x, y;
    logic sub;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        x = WIDTH'($urandom);
        y = WIDTH'($urandom);
        sub = 1'($urandom_range(0, 1));
        exp_v[i] = model_sum(x, y, sub);
        drive(1'b1, x, y, sub);
      end else begin
        drive(1'b0, '0, '0, 1'b0);
      end
      #1;
      if (i < 4) begin
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
          n_errors++;
          $display("FAIL b2b_in_ready[%0d]: in_ready=%b, required 1", i, bus.in_ready);
        end
      end
      if (i >= 2) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== exp_v[i-2]) begin
          n_errors++;
          $display("FAIL b2b_result[%0d]: out_valid=%b out_sum=%h, required 1 %h",
                   i - 2, bus.out_valid, bus.out_sum, exp_v[i-2]);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure;
    logic [WIDTH:0] q [$];
    logic [WIDTH:0] held;
    logic [WIDTH:0] want;
    logic [WIDTH-1:0] bx [3];
    logic [WIDTH-1:0] by [3];
    logic bs [3];
    int sent, got;
    sent = 0;
    got  = 0;
    held = '0;
    for (int i = 0; i < 3; i++) begin
      bx[i] = WIDTH'($urandom);
      by[i] = WIDTH'($urandom);
      bs[i] = 1'($urandom_range(0, 1));
    end
    for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
      bus.out_ready = (cyc >= 5);
      if (sent < 3) drive(1'b1, bx[sent], by[sent], bs[sent]);
      else          drive(1'b0, '0, '0, 1'b0);
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
          n_errors++;
          $display("FAIL bp_stall[%0d]: in_ready=%b out_valid=%b, required 0 1",
                   cyc, bus.in_ready, bus.out_valid);
        end
        if (cyc == 2) begin
          held = bus.out_sum;
        end else begin
          n_checks++;
          if (bus.out_sum !== held) begin
            n_errors++;
            $display("FAIL bp_hold[%0d]: out_sum=%h, required %h", cyc, bus.out_sum, held);
          end
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_errors++;
          $display("FAIL bp_extra: out_sum=%h delivered, required no result", bus.out_sum);
        end else begin
          want = q.pop_front();
          if (bus.out_sum !== want) begin
            n_errors++;
            $display("FAIL bp_order[%0d]: out_sum=%h, required %h", got, bus.out_sum, want);
          end
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model_sum(bx[sent], by[sent], bs[sent]));
        sent++;
      end
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    tick();
    n_checks++;
    if (got != 3 || bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_count: delivered=%0d out_valid=%b after drain, required 3 0",
               got, bus.out_valid);
    end
  endtask

  task automatic test_reset_midflight;
    logic seen;
    bus.out_ready = 1'b1;
    drive(1'b1, 8'h40, 8'h40, 1'b0);
    tick();
    drive(1'b1, 8'h01, 8'h02, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 8'h11, 8'h22, 1'b0);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_sum !== '0 || bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL midflight_reset: out_valid=%b out_sum=%h in_ready=%b, required 0 000 1",
               bus.out_valid, bus.out_sum, bus.in_ready);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0);
    seen = 1'b0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      #1;
      if (bus.out_valid) begin
        seen = 1'b1;
        n_checks++;
        if (bus.out_sum !== 9'h033) begin
          n_errors++;
          $display("FAIL midflight_first: out_sum=%h, required 033", bus.out_sum);
        end
      end
      tick();
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL midflight_timeout: no result within 10 cycles, required one");
    end
  endtask

`ifdef ADDSUB_OVF_EN
  task automatic test_ovf;
    bus.out_ready = 1'b1;
    drive(1'b1, 8'h01, 8'h7F, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 9'h080 || bus.out_ovf !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_flag: out_valid=%b out_sum=%h out_ovf=%b, required 1 080 1",
               bus.out_valid, bus.out_sum, bus.out_ovf);
    end
    tick();
  endtask
`endif

  task automatic test_random;
    logic [WIDTH+1:0] q [$];
    logic [WIDTH+1:0] want;
    logic [WIDTH:0] held;
    logic held_ovf;
    logic was_stalled;
    logic [WIDTH-1:0] x, y;
    logic sub, ovf;
    int accepted;
    accepted    = 0;
    was_stalled = 1'b0;
    held        = '0;
    held_ovf    = 1'b0;
    for (int cyc = 0; cyc < 20000 && (accepted < 1000 || q.size() != 0); cyc++) begin
      x   = WIDTH'($urandom);
      y   = WIDTH'($urandom);
      sub = 1'($urandom_range(0, 1));
      drive((accepted < 1000) && ($urandom_range(0, 9) < 7), x, y, sub);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      #1;
      ovf = 1'b0;
`ifdef ADDSUB_OVF_EN
      ovf = bus.out_ovf;
`endif
      if (was_stalled) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== held || ovf !== held_ovf) begin
          n_errors++;
          $display("FAIL rand_hold[%0d]: out_valid=%b out_sum=%h ovf=%b, required 1 %h %b",
                   cyc, bus.out_valid, bus.out_sum, ovf, held, held_ovf);
        end
      end
      n_checks++;
      if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
        n_errors++;
        $display("FAIL rand_in_ready[%0d]: in_ready=%b, required %b", cyc, bus.in_ready,
                 !bus.out_valid || bus.out_ready);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_errors++;
          $display("FAIL rand_spurious[%0d]: out_sum=%h with nothing in flight", cyc,
                   bus.out_sum);
        end else begin
          want = q.pop_front();
          if ({ovf, bus.out_sum} !== want) begin
            n_errors++;
            $display("FAIL rand_result[%0d]: ovf,sum=%b,%h, required %b,%h", cyc, ovf,
                     bus.out_sum, want[WIDTH+1], want[WIDTH:0]);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
`ifdef ADDSUB_OVF_EN
        q.push_back({model_ovf(x, y, sub), model_sum(x, y, sub)});
`else
        q.push_back({1'b0, model_sum(x, y, sub)});
`endif
        accepted++;
      end
      was_stalled = bus.out_valid && !bus.out_ready;
      held        = bus.out_sum;
      held_ovf    = ovf;
      tick();
    end
    n_checks++;
    if (accepted != 1000 || q.size() != 0) begin
      n_errors++;
      $display("FAIL rand_drain: accepted=%0d pending=%0d, required 1000 0", accepted, q.size());
    end
    drive(1'b0, '0, '0, 1'b0);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    test_reset();
    test_carry_chain();
    test_subtract();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
`ifdef ADDSUB_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
